// File: rtl/aibnd_clkgate_ctrl.sv
// Multi-channel clock-gate controller: per-channel enable synchroniser, OFF/WAKE/ON/DRAIN sequencer, registered gate enable and ack.
// Optional latch-based gated clock outputs are built when AIBND_CLKGATE_GCLK_EN is defined.
module aibnd_clkgate_ctrl #(
    parameter int NCH       = 4,
    parameter int SYNC_STG  = 2,
    parameter int WAKE_CYC  = 2,
    parameter int DRAIN_CYC = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] en_req,
    input  logic           force_on,
    output logic [NCH-1:0] gate_en,
    output logic [NCH-1:0] en_ack,
    output logic           busy,
    output logic [NCH-1:0] gclk_out,
    input  logic           vccl_aibnd,
    input  logic           vssl_aibnd
);

    localparam int MAXC = (WAKE_CYC > DRAIN_CYC) ? WAKE_CYC : DRAIN_CYC;
    localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    logic           r_force_q;
    logic [NCH-1:0] w_fsm_gate;
    logic [NCH-1:0] w_ack;
    logic [NCH-1:0] w_busy;
    logic           w_unused_pwr;

    assign w_unused_pwr = vccl_aibnd ^ vssl_aibnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_force_q <= 1'b0;
        end else begin
            r_force_q <= force_on;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [SYNC_STG-1:0] r_sync;
        state_t              r_state;
        logic [CW-1:0]       r_cnt;
        logic                r_gate;
        logic                r_ack;
        logic                r_busy;
        logic                w_es;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STG-2:0], en_req[g]};
            end
        end

        assign w_es = r_sync[SYNC_STG-1];

        // Output flops are loaded alongside the state so they always reflect the state just entered.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_OFF;
                r_cnt   <= '0;
                r_gate  <= 1'b0;
                r_ack   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        if (w_es) begin
                            r_state <= ST_WAKE;
                            r_cnt   <= CW'(WAKE_CYC);
                            r_gate  <= 1'b1;
                            r_ack   <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_WAKE: begin
                        if (!w_es) begin
                            r_state <= ST_OFF;
                            r_cnt   <= '0;
                            r_gate  <= 1'b0;
                            r_ack   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == '0) begin
                            r_state <= ST_ON;
                            r_ack   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    ST_ON: begin
                        if (!w_es) begin
                            r_state <= ST_DRAIN;
                            r_cnt   <= CW'(DRAIN_CYC);
                            r_ack   <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        // A returning request re-arms straight to ON; the clock never stopped, so no wake is needed.
                        if (w_es) begin
                            r_state <= ST_ON;
                            r_cnt   <= '0;
                            r_ack   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == '0) begin
                            r_state <= ST_OFF;
                            r_gate  <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_OFF;
                        r_cnt   <= '0;
                        r_gate  <= 1'b0;
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end

        assign w_fsm_gate[g] = r_gate;
        assign w_ack[g]      = r_ack;
        assign w_busy[g]     = r_busy;
    end

    assign gate_en = w_fsm_gate | {NCH{r_force_q}};
    assign en_ack  = w_ack;
    assign busy    = |w_busy;

`ifdef AIBND_CLKGATE_GCLK_EN
    // Enable is captured while clk is low, so it can only change outside the high phase.
    logic [NCH-1:0] r_en_lat;

    always_latch begin
        if (!rst_n) begin
            r_en_lat <= '0;
        end else if (!clk) begin
            r_en_lat <= gate_en;
        end
    end

    assign gclk_out = {NCH{clk}} & r_en_lat;
`else
    assign gclk_out = {NCH{1'b0}};
`endif

endmodule

// File: tb/tb_aibnd_clkgate_ctrl.sv
// Self-checking bench for aibnd_clkgate_ctrl: directed wake/drain/abort/force/reset scenarios plus
// randomized traffic against a countdown-timer reference model.
module tb_aibnd_clkgate_ctrl;

    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int WC  = 2;
    localparam int DC  = 3;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] en_req;
    logic           force_on;
    logic [NCH-1:0] gate_en;
    logic [NCH-1:0] en_ack;
    logic           busy;
    logic [NCH-1:0] gclk_out;
    logic           vccl;
    logic           vssl;

    int testsRun;
    int testsFailed;

    aibnd_clkgate_ctrl #(
        .NCH      (NCH),
        .SYNC_STG (SS),
        .WAKE_CYC (WC),
        .DRAIN_CYC(DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_req    (en_req),
        .force_on  (force_on),
        .gate_en   (gate_en),
        .en_ack    (en_ack),
        .busy      (busy),
        .gclk_out  (gclk_out),
        .vccl_aibnd(vccl),
        .vssl_aibnd(vssl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: delay line for the synchroniser, countdown timers for wake and drain windows.
    bit mPipe  [NCH][SS];
    bit mGate  [NCH];
    bit mAck   [NCH];
    int mWake  [NCH];
    int mDrain [NCH];
    bit mForceQ;

    function automatic void modelReset();
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < SS; k++) mPipe[c][k] = 1'b0;
            mGate[c]  = 1'b0;
            mAck[c]   = 1'b0;
            mWake[c]  = 0;
            mDrain[c] = 0;
        end
        mForceQ = 1'b0;
    endfunction

    function automatic void modelEdge();
        bit es;
        if (rst_n !== 1'b1) return;
        for (int c = 0; c < NCH; c++) begin
            es = mPipe[c][SS-1];
            if (!mGate[c]) begin
                if (es) begin
                    mGate[c] = 1'b1;
                    mWake[c] = WC + 1;
                end
            end else if (mWake[c] > 0) begin
                if (!es) begin
                    mGate[c] = 1'b0;
                    mWake[c] = 0;
                end else begin
                    mWake[c]--;
                    if (mWake[c] == 0) mAck[c] = 1'b1;
                end
            end else if (mAck[c]) begin
                if (!es) begin
                    mAck[c]   = 1'b0;
                    mDrain[c] = DC + 1;
                end
            end else begin
                if (es) begin
                    mAck[c]   = 1'b1;
                    mDrain[c] = 0;
                end else begin
                    mDrain[c]--;
                    if (mDrain[c] == 0) mGate[c] = 1'b0;
                end
            end
            for (int k = SS - 1; k > 0; k--) mPipe[c][k] = mPipe[c][k-1];
            mPipe[c][0] = en_req[c];
        end
        mForceQ = force_on;
    endfunction

    function automatic logic [2*NCH:0] modelOut();
        logic [NCH-1:0] g;
        logic [NCH-1:0] a;
        logic           b;
        b = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            g[c] = mGate[c] | mForceQ;
            a[c] = mAck[c];
            b    = b | (mGate[c] & ~mAck[c]);
        end
        return {g, a, b};
    endfunction

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic settle();
        en_req   = '0;
        force_on = 1'b0;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        en_req   = 4'hF;
        force_on = 1'b0;
        modelReset();
        #3;
        testsRun++;
        if ({gate_en, en_ack, busy, gclk_out} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs got %b want 0", {gate_en, en_ack, busy, gclk_out});
        end
        step();
        step();
        testsRun++;
        if ({gate_en, en_ack, busy, gclk_out} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_held got %b want 0", {gate_en, en_ack, busy, gclk_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            testsRun++;
            if (gate_en !== ((e == 3) ? 4'hF : 4'h0)) begin
                testsFailed++;
                $display("[TB] FAIL reset_release edge %0d gate_en got %h want %h", e, gate_en, (e == 3) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_wake();
        logic [2:0] want;
        settle();
        en_req = 4'b0001;
        for (int e = 1; e <= 7; e++) begin
            step();
            want = {1'(e >= 3), 1'(e >= 6), 1'(e >= 3 && e <= 5)};
            testsRun++;
            if ({gate_en[0], en_ack[0], busy} !== want || {gate_en, en_ack, busy} !== modelOut()) begin
                testsFailed++;
                $display("[TB] FAIL wake edge %0d got g/a/b %b want %b", e, {gate_en[0], en_ack[0], busy}, want);
            end
        end
    endtask

    task automatic test_drain();
        logic [2:0] want;
        en_req = 4'b0000;
        for (int e = 1; e <= 8; e++) begin
            step();
            want = {1'(e <= 6), 1'(e < 3), 1'(e >= 3 && e <= 6)};
            testsRun++;
            if ({gate_en[0], en_ack[0], busy} !== want || {gate_en, en_ack, busy} !== modelOut()) begin
                testsFailed++;
                $display("[TB] FAIL drain edge %0d got g/a/b %b want %b", e, {gate_en[0], en_ack[0], busy}, want);
            end
        end
    endtask

    task automatic test_rearm();
        logic [1:0] want;
        settle();
        en_req = 4'b0001;
        for (int i = 0; i < 7; i++) step();
        en_req = 4'b0000;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 4) en_req = 4'b0001;
            want = {1'b1, 1'(e < 3 || e >= 7)};
            testsRun++;
            if ({gate_en[0], en_ack[0]} !== want || {gate_en, en_ack, busy} !== modelOut()) begin
                testsFailed++;
                $display("[TB] FAIL rearm edge %0d got g/a %b want %b", e, {gate_en[0], en_ack[0]}, want);
            end
        end
    endtask

    task automatic test_abort();
        logic [2:0] want;
        settle();
        en_req = 4'b0010;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (e == 3) en_req = 4'b0000;
            want = {1'(e >= 3 && e <= 5), 1'b0, 1'(e >= 3 && e <= 5)};
            testsRun++;
            if ({gate_en[1], en_ack[1], busy} !== want || {gate_en, en_ack, busy} !== modelOut()) begin
                testsFailed++;
                $display("[TB] FAIL abort edge %0d got g/a/b %b want %b", e, {gate_en[1], en_ack[1], busy}, want);
            end
        end
    endtask

    task automatic test_force();
        settle();
        force_on = 1'b1;
        step();
        testsRun++;
        if ({gate_en, en_ack, busy} !== {4'hF, 4'h0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL force_on got %b want %b", {gate_en, en_ack, busy}, {4'hF, 4'h0, 1'b0});
        end
        step();
        step();
        force_on = 1'b0;
        step();
        testsRun++;
        if ({gate_en, en_ack, busy} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL force_release got %b want 0", {gate_en, en_ack, busy});
        end
    endtask

    task automatic test_reset_mid();
        settle();
        en_req = 4'b0100;
        for (int i = 0; i < 4; i++) step();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        testsRun++;
        if ({gate_en, en_ack, busy, gclk_out} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid got %b want 0", {gate_en, en_ack, busy, gclk_out});
        end
        en_req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            testsRun++;
            if ({gate_en, en_ack, busy} !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid_after edge %0d got %b want 0", e, {gate_en, en_ack, busy});
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(7) == 0) en_req[c] = ~en_req[c];
            end
            if ($urandom_range(15) == 0) force_on = ~force_on;
            step();
            testsRun++;
            if ({gate_en, en_ack, busy} !== modelOut() || (en_ack & ~gate_en) !== '0) begin
                testsFailed++;
                $display("[TB] FAIL random cyc %0d got g/a/b %b want %b", cyc, {gate_en, en_ack, busy}, modelOut());
            end
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        vccl        = 1'b1;
        vssl        = 1'b0;
        rst_n       = 1'b0;
        en_req      = '0;
        force_on    = 1'b0;
        modelReset();
        test_reset();
        test_wake();
        test_drain();
        test_rearm();
        test_abort();
        test_force();
        test_reset_mid();
        settle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout run did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
